// File: rtl/tss_pkg.sv
// -----------------------------------------------------------------------------
// tss_pkg
// Shared definitions for the event-capture Wishbone slave:
//   - byte offsets of the event-capture registers
//   - evc_entry_t: one captured timestamp {edge type, seconds, nanoseconds}
//   - wb_state_t:  state of the single-beat Wishbone acknowledge FSM
// -----------------------------------------------------------------------------
package tss_pkg;

    // Register byte offsets; only bits [4:2] are decoded by the slave.
    localparam logic [7:0] EVC_CTRL      = 8'h00;
    localparam logic [7:0] EVC_STATUS    = 8'h04;
    localparam logic [7:0] EVC_TS_NS     = 8'h08;
    localparam logic [7:0] EVC_TS_SEC_LO = 8'h0C;
    localparam logic [7:0] EVC_TS_SEC_HI = 8'h10;

    // CTRL bit positions
    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_RISE = 1;
    localparam int unsigned CTRL_FALL = 2;
    localparam int unsigned CTRL_CLR  = 3;

    // One FIFO entry. etype = 1 for a rising edge, 0 for a falling edge.
    typedef struct packed {
        logic        etype;
        logic [47:0] sec;
        logic [31:0] ns;
    } evc_entry_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_t;

    // Word index of a register byte offset.
    function automatic logic [2:0] reg_index(input logic [7:0] offset);
        return offset[4:2];
    endfunction

endpackage

// File: rtl/ts_evt_fifo.sv
// -----------------------------------------------------------------------------
// ts_evt_fifo
// Synchronous first-word-fall-through FIFO for captured timestamps.
//   clk, arst   clock, asynchronous active-high reset
//   flush       empties the FIFO; overrides push and pop in the same cycle
//   push        write push_data (accepted when not full, or when full and
//               a pop happens in the same cycle)
//   push_data   entry to store
//   pop         discard the head entry (ignored while empty)
//   head        current oldest entry, valid whenever empty = 0
//   full, empty occupancy flags
//   level       number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ts_evt_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter type         entry_t = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        do_pop  = pop & (count != '0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push = push & ((count != FULL_CNT) | do_pop);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/ts_event_capture.sv
// -----------------------------------------------------------------------------
// ts_event_capture
// Timestamps edges of an asynchronous event input against the PTP RTC and
// queues the stamps for software, which reads them over Wishbone.
//   clk          RTC / Wishbone clock
//   arst         asynchronous active-high reset
//   evt_i        asynchronous event input (synchronized here)
//   rtc_sec_i    RTC seconds (48 bit)
//   rtc_ns_i     RTC nanoseconds (32 bit)
//   wbs_addr_i   byte address, bits [4:2] decoded
//   wbs_data_i   write data
//   wbs_data_o   registered read data, valid with ack, 0 otherwise
//   wbs_we_i     write enable
//   wbs_stb_i    strobe (already qualified by cyc)
//   wbs_ack_o    single-cycle acknowledge, one cycle after strobe
//   irq_o        high while the FIFO holds entries and CTRL.en = 1
// Registers: 0x00 CTRL, 0x04 STATUS, 0x08 TS_NS, 0x0C TS_SEC_LO,
//            0x10 TS_SEC_HI (reading it pops the head entry).
// Stamps carry a fixed two-cycle latency that software compensates.
// -----------------------------------------------------------------------------
module ts_event_capture
    import tss_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned OVF_W = 8
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        evt_i,
    input  logic [47:0] rtc_sec_i,
    input  logic [31:0] rtc_ns_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_data_i,
    output logic [31:0] wbs_data_o,
    input  logic        wbs_we_i,
    input  logic        wbs_stb_i,
    output logic        wbs_ack_o,
    output logic        irq_o
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    localparam logic [2:0] IDX_CTRL      = reg_index(EVC_CTRL);
    localparam logic [2:0] IDX_STATUS    = reg_index(EVC_STATUS);
    localparam logic [2:0] IDX_TS_NS     = reg_index(EVC_TS_NS);
    localparam logic [2:0] IDX_TS_SEC_LO = reg_index(EVC_TS_SEC_LO);
    localparam logic [2:0] IDX_TS_SEC_HI = reg_index(EVC_TS_SEC_HI);

    // Event synchronizer and edge detect
    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             rise_det;
    logic             fall_det;

    // Control / status state
    logic             en;
    logic             rise;
    logic             fall;
    logic             clr_q;
    logic [OVF_W-1:0] ovf_cnt;

    // Wishbone
    wb_state_t        wb_state;
    logic [2:0]       idx;
    logic             access;
    logic             ctrl_wr;
    logic             ts_pop;
    logic [31:0]      status_word;
    logic [31:0]      rd_data;

    // FIFO interface
    logic             push;
    logic             pop;
    logic             ovf_inc;
    evc_entry_t       push_data;
    evc_entry_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LW-1:0]    level;

    logic             unused_bits;

    // -------------------------------------------------------------------------
    // Event input: 2-FF synchronizer followed by a previous-value register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= evt_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise_det = sync2 & ~prev;
    assign fall_det = ~sync2 & prev;

    // -------------------------------------------------------------------------
    // Access decode. An access is a strobe seen while no ack is outstanding.
    // -------------------------------------------------------------------------
    always_comb begin
        idx     = wbs_addr_i[4:2];
        access  = wbs_stb_i & (wb_state == WB_IDLE);
        ctrl_wr = access & wbs_we_i & (idx == IDX_CTRL);
        ts_pop  = access & ~wbs_we_i & (idx == IDX_TS_SEC_HI);
    end

    // -------------------------------------------------------------------------
    // Push / pop. The cycle after a clr write flushes the FIFO, so anything
    // detected or popped in that cycle is dropped rather than counted.
    // -------------------------------------------------------------------------
    always_comb begin
        push          = en & ((rise & rise_det) | (fall & fall_det)) & ~clr_q;
        pop           = ts_pop & ~clr_q;
        ovf_inc       = push & fifo_full & ~pop;
        push_data     = '0;
        push_data.etype = sync2;
        push_data.sec   = rtc_sec_i;
        push_data.ns    = rtc_ns_i;
    end

    ts_evt_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (evc_entry_t)
    ) u_fifo (
        .clk       (clk),
        .arst      (arst),
        .flush     (clr_q),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // -------------------------------------------------------------------------
    // CTRL register, self-clearing clr and saturating overflow counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            en      <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            clr_q   <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            clr_q <= ctrl_wr & wbs_data_i[CTRL_CLR];
            if (ctrl_wr) begin
                en   <= wbs_data_i[CTRL_EN];
                rise <= wbs_data_i[CTRL_RISE];
                fall <= wbs_data_i[CTRL_FALL];
            end
            if (clr_q) begin
                ovf_cnt <= '0;
            end else if (ovf_inc && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read mux; TS registers read 0 while the FIFO is empty
    // -------------------------------------------------------------------------
    always_comb begin
        status_word         = '0;
        status_word[LW-1:0] = level;
        status_word[8]      = fifo_empty;
        status_word[9]      = fifo_full;
        status_word[23:16]  = 8'(ovf_cnt);

        rd_data = '0;
        case (idx)
            IDX_CTRL:      rd_data = {28'd0, 1'b0, fall, rise, en};
            IDX_STATUS:    rd_data = status_word;
            IDX_TS_NS:     rd_data = fifo_empty ? '0 : head.ns;
            IDX_TS_SEC_LO: rd_data = fifo_empty ? '0 : head.sec[31:0];
            IDX_TS_SEC_HI: rd_data = fifo_empty ? '0
                                     : {head.etype, 15'd0, head.sec[47:32]};
            default:       rd_data = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Wishbone acknowledge FSM: one ack cycle per access, data only with ack
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wb_state   <= WB_IDLE;
            wbs_ack_o  <= 1'b0;
            wbs_data_o <= '0;
        end else begin
            case (wb_state)
                WB_IDLE: begin
                    if (wbs_stb_i) begin
                        wb_state   <= WB_ACK;
                        wbs_ack_o  <= 1'b1;
                        wbs_data_o <= wbs_we_i ? '0 : rd_data;
                    end else begin
                        wbs_ack_o  <= 1'b0;
                        wbs_data_o <= '0;
                    end
                end
                WB_ACK: begin
                    wb_state   <= WB_IDLE;
                    wbs_ack_o  <= 1'b0;
                    wbs_data_o <= '0;
                end
                default: begin
                    wb_state   <= WB_IDLE;
                    wbs_ack_o  <= 1'b0;
                    wbs_data_o <= '0;
                end
            endcase
        end
    end

    assign irq_o = en & ~fifo_empty;

    assign unused_bits = ^{wbs_addr_i[31:5], wbs_addr_i[1:0], wbs_data_i[31:4]};

endmodule

// File: tb/tb_ts_event_capture.sv
module tb_ts_event_capture;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned OVF_W = 8;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        evt = 1'b0;
    logic [47:0] rtc_sec = '0;
    logic [31:0] rtc_ns = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] rdata;
    logic        ack;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #4 clk = ~clk;

    ts_event_capture #(
        .DEPTH (DEPTH),
        .OVF_W (OVF_W)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .evt_i      (evt),
        .rtc_sec_i  (rtc_sec),
        .rtc_ns_i   (rtc_ns),
        .wbs_addr_i (addr),
        .wbs_data_i (wdata),
        .wbs_data_o (rdata),
        .wbs_we_i   (we),
        .wbs_stb_i  (stb),
        .wbs_ack_o  (ack),
        .irq_o      (irq)
    );

    // Free-running RTC, advanced just after each rising edge (+8 ns per clock)
    always @(posedge clk) begin
        #1;
        if (rtc_ns >= 32'd999_999_992) begin
            rtc_ns  = rtc_ns - 32'd999_999_992;
            rtc_sec = rtc_sec + 48'd1;
        end else begin
            rtc_ns = rtc_ns + 32'd8;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: event levels sampled at each edge, a queue of
    // stamps, and the register file as plain variables.
    // ---------------------------------------------------------------------
    typedef struct {
        bit        etype;
        bit [47:0] sec;
        bit [31:0] ns;
    } stamp_t;

    stamp_t      mq[$];
    int unsigned m_ovf = 0;
    bit          m_en = 0, m_rise = 0, m_fall = 0, m_clr = 0;
    bit          m_ack = 0;
    bit [31:0]   m_data = '0;
    bit [2:0]    m_hist = '0;   // [0]=level sampled one edge ago, [1]=two, [2]=three
    bit          m_access, m_push, m_pop, m_risee, m_falle;
    bit [31:0]   m_next;
    stamp_t      m_s;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r = '0;
        int n = mq.size();
        case (a[4:2])
            3'd0: r = {28'd0, 1'b0, m_fall, m_rise, m_en};
            3'd1: begin
                r[6:0]   = 7'(n);
                r[8]     = (n == 0);
                r[9]     = (n == DEPTH);
                r[23:16] = 8'(m_ovf);
            end
            3'd2: if (n != 0) r = mq[0].ns;
            3'd3: if (n != 0) r = mq[0].sec[31:0];
            3'd4: if (n != 0) r = {mq[0].etype, 15'd0, mq[0].sec[47:32]};
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            mq.delete();
            m_ovf = 0; m_en = 0; m_rise = 0; m_fall = 0; m_clr = 0;
            m_ack = 0; m_data = '0; m_hist = '0;
        end else begin
            m_access = stb && !m_ack;
            m_next   = (m_access && !we) ? model_read(addr) : 32'd0;
            m_pop    = m_access && !we && (addr[4:2] == 3'd4) && (mq.size() != 0);
            // An edge sampled at edge n-2 is pushed at edge n.
            m_risee  = m_hist[1] && !m_hist[2];
            m_falle  = !m_hist[1] && m_hist[2];
            m_push   = m_en && ((m_rise && m_risee) || (m_fall && m_falle));
            m_s.etype = m_hist[1];
            m_s.sec   = rtc_sec;
            m_s.ns    = rtc_ns;
            if (m_clr) begin
                mq.delete();
                m_ovf = 0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    if (mq.size() < DEPTH) mq.push_back(m_s);
                    else if (m_ovf < (1 << OVF_W) - 1) m_ovf++;
                end
            end
            m_clr = m_access && we && (addr[4:2] == 3'd0) && wdata[3];
            if (m_access && we && (addr[4:2] == 3'd0)) begin
                m_en   = wdata[0];
                m_rise = wdata[1];
                m_fall = wdata[2];
            end
            m_ack  = m_access;
            m_data = m_next;
            m_hist = {m_hist[1:0], evt};
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("rdata", rdata, m_data);
        chk("irq", {31'd0, irq}, {31'd0, (mq.size() != 0) && m_en});
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (called and returning on a falling edge)
    // ---------------------------------------------------------------------
    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] q);
        stb = 1'b1; we = wr; addr = a; wdata = d;
        @(negedge clk);
        q = rdata;
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] q;

    initial begin
        idle(3);
        arst = 1'b0;
        idle(1);

        // Reset state
        chk("rst_irq", {31'd0, irq}, 32'd0);
        wb(0, 32'h04, 0, q); chk("rst_status", q, 32'h0000_0100);
        wb(0, 32'h00, 0, q); chk("rst_ctrl", q, 32'h0);

        // Rising capture; stamp is the RTC two edges after the sampling edge
        wb(1, 32'h00, 32'h3, q);
        rtc_sec = 48'd5; rtc_ns = 32'd1000; evt = 1'b1;
        idle(2); chk("lat_irq_lo", {31'd0, irq}, 32'd0);
        idle(1); chk("lat_irq_hi", {31'd0, irq}, 32'd1);
        wb(0, 32'h04, 0, q); chk("cap_status", q, 32'h0000_0001);
        wb(0, 32'h08, 0, q); chk("cap_ns", q, 32'd1016);
        wb(0, 32'h0C, 0, q); chk("cap_seclo", q, 32'd5);
        wb(0, 32'h10, 0, q); chk("cap_sechi", q, 32'h8000_0000);
        wb(0, 32'h04, 0, q); chk("pop_status", q, 32'h0000_0100);
        chk("pop_irq", {31'd0, irq}, 32'd0);

        // Edge select: falling only
        wb(1, 32'h00, 32'h0, q);
        evt = 1'b0; idle(4);
        wb(1, 32'h00, 32'h5, q);
        evt = 1'b1; idle(4);
        evt = 1'b0; idle(4);
        wb(0, 32'h04, 0, q); chk("sel_status", q, 32'h0000_0001);
        wb(0, 32'h10, 0, q); chk("sel_type", q, 32'h0000_0000);
        wb(0, 32'h04, 0, q); chk("sel_empty", q, 32'h0000_0100);

        // Overflow: 20 edges, 4 clocks apart
        wb(1, 32'h00, 32'h7, q);
        rtc_sec = 48'd5; rtc_ns = 32'd1000;
        for (int i = 0; i < 20; i++) begin
            evt = ~evt;
            idle(4);
        end
        wb(0, 32'h04, 0, q); chk("ovf_status", q, 32'h0004_0210);

        // Full FIFO: pop ack lands on the push edge of a new event
        evt = ~evt;
        idle(2);
        wb(0, 32'h10, 0, q); chk("fullpop_head", q, 32'h8000_0000);
        wb(0, 32'h04, 0, q); chk("fullpop_status", q, 32'h0004_0210);
        wb(0, 32'h08, 0, q); chk("order_ns1", q, 32'd1048);

        // Clear in the same cycle an edge is detected
        evt = ~evt;
        idle(1);
        wb(1, 32'h00, 32'hF, q);
        wb(0, 32'h04, 0, q); chk("clr_status", q, 32'h0000_0100);
        wb(0, 32'h00, 0, q); chk("clr_ctrl", q, 32'h0000_0007);

        // Reset during an access
        evt = ~evt; idle(4);
        evt = ~evt; idle(4);
        stb = 1'b1; we = 1'b0; addr = 32'h04;
        #1 arst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack", {31'd0, ack}, 32'd0);
        chk("rst_mid_data", rdata, 32'd0);
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        stb = 1'b0;
        idle(1);
        arst = 1'b0;
        idle(2);
        wb(0, 32'h04, 0, q); chk("rst_mid_status", q, 32'h0000_0100);
        wb(0, 32'h00, 0, q); chk("rst_mid_ctrl", q, 32'h0);

        // Randomized traffic, including an RTC seconds rollover
        rtc_sec = 48'hFFFF_FFFF_FFF0; rtc_ns = 32'd999_990_000;
        for (int ph = 0; ph < 2; ph++) begin
            for (int it = 0; it < 1500; it++) begin
                int unsigned r;
                int unsigned idx;
                logic [31:0] d;
                r = $urandom_range(0, 99);
                if (r < ((ph == 0) ? 30 : 5)) evt = ~evt;
                if ($urandom_range(0, 99) < 35) begin
                    if ($urandom_range(0, 99) < 15) begin
                        idx = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(0, 7);
                        d = $urandom();
                        d[0] = ($urandom_range(0, 3) != 0);
                        d[3] = ($urandom_range(0, 19) == 0);
                        wb(1, ($urandom() & 32'hFFFF_FFE3) | (32'(idx) << 2), d, q);
                    end else begin
                        idx = (ph == 1 && $urandom_range(0, 1) == 1) ? 4 : $urandom_range(0, 7);
                        wb(0, ($urandom() & 32'hFFFF_FFE3) | (32'(idx) << 2), 0, q);
                    end
                end else begin
                    idle(1);
                end
            end
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
